// File: rtl/hilo_seq.sv
`default_nettype none
// ============================================================================
// Module      : hilo_seq
// Description : Sequenced HI/LO register stage behind the combinational
//               32x32 multiplier. A MULT/MULTU issue stalls the CPU for
//               MUL_LAT cycles while the product settles. The 64-bit product
//               is then committed into HI/LO. MTHI/MTLO writes are serviced
//               while idle, and HI/LO are always presented for MFHI/MFLO.
//
// Parameters  : MUL_LAT   settle cycles before capture (legal 1..15)
//
// Ports       : clk        system clock, rising edge
//               rst        synchronous active-high reset
//               start_mul  multiply issue strobe (sampled in IDLE only)
//               mul_hi     upper product word from the multiplier
//               mul_lo     lower product word from the multiplier
//               mthi       write wdata into HI (IDLE only)
//               mtlo       write wdata into LO (IDLE only)
//               wdata      GPR data for MTHI/MTLO
//               hi         architectural HI register
//               lo         architectural LO register
//               busy       stall request while a multiply is in flight
//               done       one-cycle pulse after the product is committed
//
// Revision    : 1.0  initial release
// ============================================================================
module hilo_seq #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_mul,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_WAIT     = 1'b1;
    // The counter is loaded with MUL_LAT-1, so the commit lands on the
    // MUL_LAT-th edge after the issue edge.
    localparam logic [3:0] c_CNT_INIT = 4'(MUL_LAT - 1);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Also aborts an in-flight multiply: no commit, HI/LO cleared.
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'h0000_0000;
            r_lo    <= 32'h0000_0000;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // A move issued together with a multiply is applied now;
                    // the later commit overwrites both registers anyway.
                    if (mthi) begin
                        r_hi <= wdata;
                    end
                    if (mtlo) begin
                        r_lo <= wdata;
                    end
                    if (start_mul) begin
                        r_state <= c_WAIT;
                        r_cnt   <= c_CNT_INIT;
                    end
                end
                c_WAIT: begin
                    // CPU is stalled here; moves and issues are ignored.
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_hi    <= mul_hi;
                        r_lo    <= mul_lo;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == c_WAIT);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_seq
// Description : Self-checking bench for hilo_seq (MUL_LAT = 2). Stimulus
//               pushes expected HI/LO products into a queue; a monitor
//               thread pops and compares on every done pulse.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_seq;

    logic        clk;
    logic        rst;
    logic        start_mul;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   n_done;

    hilo_seq #(.MUL_LAT(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start_mul (start_mul),
        .mul_hi    (mul_hi),
        .mul_lo    (mul_lo),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are observed there too.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        exp_q.push_back(e);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        n_done    = 0;
        rst       = 1'b1;
        start_mul = 1'b0;
        mul_hi    = 32'h0;
        mul_lo    = 32'h0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        wdata     = 32'h0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (done === 1'b1) begin
                        n_done++;
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no commit", hi, lo);
                        end else begin
                            e = exp_q.pop_front();
                            chk("commit_hi", {32'h0, hi}, {32'h0, e.hi});
                            chk("commit_lo", {32'h0, lo}, {32'h0, e.lo});
                        end
                    end
                end
            end
            begin : stimulus
                step();
                step();
                rst = 1'b0;

                // Reset state held through five idle cycles
                for (int i = 0; i < 5; i++) begin
                    step();
                    chk("idle_hi",   {32'h0, hi}, 64'h0);
                    chk("idle_lo",   {32'h0, lo}, 64'h0);
                    chk("idle_busy", {63'h0, busy}, 64'h0);
                    chk("idle_done", {63'h0, done}, 64'h0);
                end

                // Unsigned 0xFFFFFFFF squared
                mul_hi = 32'hFFFF_FFFE;
                mul_lo = 32'h0000_0001;
                start_mul = 1'b1;
                push(32'hFFFF_FFFE, 32'h0000_0001);
                step();
                start_mul = 1'b0;
                chk("t1_busy_c1", {63'h0, busy}, 64'h1);
                step();
                chk("t1_busy_c2", {63'h0, busy}, 64'h1);
                chk("t1_nodone",  {63'h0, done}, 64'h0);
                step();
                chk("t1_busy_end", {63'h0, busy}, 64'h0);
                chk("t1_done",     {63'h0, done}, 64'h1);
                step();
                chk("t1_done_clr", {63'h0, done}, 64'h0);

                // Signed -1 x -1 issued together with MTHI
                mul_hi = 32'h0000_0000;
                mul_lo = 32'h0000_0001;
                wdata = 32'h1234_5678;
                mthi = 1'b1;
                start_mul = 1'b1;
                push(32'h0000_0000, 32'h0000_0001);
                step();
                mthi = 1'b0;
                start_mul = 1'b0;
                chk("t2_mthi_hi", {32'h0, hi}, {32'h0, 32'h1234_5678});
                chk("t2_busy",    {63'h0, busy}, 64'h1);
                step();
                step();
                chk("t2_done", {63'h0, done}, 64'h1);
                chk("t2_hi",   {32'h0, hi}, 64'h0);

                // Moves and issue during WAIT are ignored
                mul_hi = 32'hCAFE_F00D;
                mul_lo = 32'h0BAD_C0DE;
                start_mul = 1'b1;
                push(32'hCAFE_F00D, 32'h0BAD_C0DE);
                step();
                mthi = 1'b1;
                mtlo = 1'b1;
                wdata = 32'hDEAD_BEEF;
                step();
                chk("t3_wait_hi", {32'h0, hi}, 64'h0);
                chk("t3_wait_lo", {32'h0, lo}, 64'h1);
                step();
                mthi = 1'b0;
                mtlo = 1'b0;
                start_mul = 1'b0;
                chk("t3_done", {63'h0, done}, 64'h1);
                step();
                chk("t3_one_pulse", {63'h0, done}, 64'h0);
                chk("t3_no_restart", {63'h0, busy}, 64'h0);

                // Reset in the first WAIT cycle aborts the multiply
                wdata = 32'hAAAA_5555;
                mthi = 1'b1;
                step();
                mthi = 1'b0;
                chk("t4_mthi", {32'h0, hi}, {32'h0, 32'hAAAA_5555});
                start_mul = 1'b1;
                step();
                start_mul = 1'b0;
                chk("t4_busy", {63'h0, busy}, 64'h1);
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("t4_rst_hi",   {32'h0, hi}, 64'h0);
                chk("t4_rst_lo",   {32'h0, lo}, 64'h0);
                chk("t4_rst_busy", {63'h0, busy}, 64'h0);
                chk("t4_rst_done", {63'h0, done}, 64'h0);
                step();
                chk("t4_no_done", {63'h0, done}, 64'h0);
                step();

                // MTLO alone, then both moves together
                wdata = 32'h5A5A_5A5A;
                mtlo = 1'b1;
                step();
                mtlo = 1'b0;
                chk("t5_mtlo_lo", {32'h0, lo}, {32'h0, 32'h5A5A_5A5A});
                chk("t5_mtlo_hi", {32'h0, hi}, 64'h0);
                wdata = 32'h0F0F_1234;
                mthi = 1'b1;
                mtlo = 1'b1;
                step();
                mthi = 1'b0;
                mtlo = 1'b0;
                chk("t5_both_hi", {32'h0, hi}, {32'h0, 32'h0F0F_1234});
                chk("t5_both_lo", {32'h0, lo}, {32'h0, 32'h0F0F_1234});

                // Back-to-back: second issue in the done cycle
                mul_hi = 32'h1111_1111;
                mul_lo = 32'h2222_2222;
                start_mul = 1'b1;
                push(32'h1111_1111, 32'h2222_2222);
                step();
                start_mul = 1'b0;
                step();
                step();
                chk("t6_done1", {63'h0, done}, 64'h1);
                chk("t6_busy_gap", {63'h0, busy}, 64'h0);
                mul_hi = 32'h3333_3333;
                mul_lo = 32'h0000_0007;
                start_mul = 1'b1;
                push(32'h3333_3333, 32'h0000_0007);
                step();
                start_mul = 1'b0;
                chk("t6_busy2_c1", {63'h0, busy}, 64'h1);
                step();
                chk("t6_busy2_c2", {63'h0, busy}, 64'h1);
                step();
                chk("t6_done2", {63'h0, done}, 64'h1);
                chk("t6_lo",    {32'h0, lo}, 64'h7);

                step();
                step();
            end
        join_any
        disable fork;

        chk("done_pulses", 64'(n_done), 64'd5);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
